// File: rtl/trigger_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : trigger_word_receiver
// Description : Receiving end of the 8-bit trigger-word link. Takes the
//               deserialized (ISERDES2) word stream, finds the bit alignment
//               from the first clean token and decodes the 4-token cycle
//               F0 (0, sync), 81 (1), 88 (2), AA (3). Flags out-of-sequence
//               tokens, non-token words at the locked offset and loss of lock.
// Ports       : clock          - fabric word clock (rising edge)
//               reset_n        - asynchronous active-low reset
//               data_in[7:0]   - deserialized word, bit 7 earliest on the wire
//               token_valid    - 1-cycle pulse, a token was decoded
//               token_index    - index of last decoded token (held)
//               sync           - pulse with token_valid when index is 0
//               sequence_error - pulse, decoded index differs from expected
//               framing_error  - pulse, nonzero non-token word while locked
//               locked         - high while aligned
//               bit_offset     - locked alignment (0 while searching)
//               error_count    - saturating error counter, present only when
//                                TRIGGER_RX_ERROR_COUNTER_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_word_receiver #(
  parameter int WIDTH          = 8,
  parameter int LOSS_THRESHOLD = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic             token_valid,
  output logic [1:0]       token_index,
  output logic             sync,
  output logic             sequence_error,
  output logic             framing_error,
  output logic             locked,
  output logic [2:0]       bit_offset
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
  ,
  output logic [15:0]      error_count
`endif
);

  localparam logic [3:0] c_loss_threshold = 4'(LOSS_THRESHOLD);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // {hit, index}
  function automatic logic [2:0] decode(input logic [7:0] c);
    logic [2:0] r;
    case (c)
      8'hF0:   r = 3'b100;
      8'h81:   r = 3'b101;
      8'h88:   r = 3'b110;
      8'hAA:   r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]   w0_q, w1_q;
  state_t             state_q, state_d;
  logic [1:0]         exp_q, exp_d;
  logic [3:0]         bad_q, bad_d;
  logic               token_valid_q, token_valid_d;
  logic [1:0]         token_index_q, token_index_d;
  logic               sync_q, sync_d;
  logic               seq_err_q, seq_err_d;
  logic               frm_err_q, frm_err_d;
  logic               locked_q, locked_d;
  logic [2:0]         bit_offset_q, bit_offset_d;

  logic [2*WIDTH-1:0] w_window;
  logic [7:0]         w_cand;
  logic [2:0]         w_cand_dec;
  logic               w_search_hit;
  logic [2:0]         w_search_off;
  logic [1:0]         w_search_idx;
  logic [7:0]         w_lock_cand;
  logic [2:0]         w_lock_dec;
  logic [3:0]         w_bad_inc;

  // Acquisition: scan offsets from high to low so the lowest match wins.
  // A candidate only counts when every older bit in the window is idle.
  always_comb begin
    w_window     = {w1_q, w0_q};
    w_cand       = 8'h00;
    w_cand_dec   = 3'b000;
    w_search_hit = 1'b0;
    w_search_off = 3'd0;
    w_search_idx = 2'd0;
    for (int s = 7; s >= 0; s--) begin
      w_cand     = w_window[s +: 8];
      w_cand_dec = decode(w_cand);
      if (w_cand_dec[2] && ((w_window >> (s + 8)) == 16'd0)) begin
        w_search_hit = 1'b1;
        w_search_off = 3'(s);
        w_search_idx = w_cand_dec[1:0];
      end
    end
  end

  always_comb begin
    w_lock_cand   = w_window[bit_offset_q +: 8];
    w_lock_dec    = decode(w_lock_cand);
    w_bad_inc     = (bad_q == 4'hF) ? bad_q : bad_q + 4'd1;

    state_d       = state_q;
    exp_d         = exp_q;
    bad_d         = bad_q;
    token_valid_d = 1'b0;
    token_index_d = token_index_q;
    sync_d        = 1'b0;
    seq_err_d     = 1'b0;
    frm_err_d     = 1'b0;
    locked_d      = locked_q;
    bit_offset_d  = bit_offset_q;

    case (state_q)
      SEARCH: begin
        if (w_search_hit) begin
          token_valid_d = 1'b1;
          token_index_d = w_search_idx;
          sync_d        = (w_search_idx == 2'd0);
          locked_d      = 1'b1;
          bit_offset_d  = w_search_off;
          exp_d         = w_search_idx + 2'd1;
          state_d       = LOCKED;
        end
      end
      LOCKED: begin
        if (w_lock_cand == 8'h00) begin
          // idle word: nothing changes
        end else if (w_lock_dec[2]) begin
          token_valid_d = 1'b1;
          token_index_d = w_lock_dec[1:0];
          sync_d        = (w_lock_dec[1:0] == 2'd0);
          seq_err_d     = (w_lock_dec[1:0] != exp_q);
          exp_d         = w_lock_dec[1:0] + 2'd1;
          bad_d         = 4'd0;
        end else begin
          frm_err_d = 1'b1;
          if (w_bad_inc == c_loss_threshold) begin
            state_d      = SEARCH;
            locked_d     = 1'b0;
            bit_offset_d = 3'd0;
            bad_d        = 4'd0;
            exp_d        = 2'd0;
          end else begin
            bad_d = w_bad_inc;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w0_q          <= '0;
      w1_q          <= '0;
      state_q       <= SEARCH;
      exp_q         <= 2'd0;
      bad_q         <= 4'd0;
      token_valid_q <= 1'b0;
      token_index_q <= 2'd0;
      sync_q        <= 1'b0;
      seq_err_q     <= 1'b0;
      frm_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      bit_offset_q  <= 3'd0;
    end else begin
      w0_q          <= data_in;
      w1_q          <= w0_q;
      state_q       <= state_d;
      exp_q         <= exp_d;
      bad_q         <= bad_d;
      token_valid_q <= token_valid_d;
      token_index_q <= token_index_d;
      sync_q        <= sync_d;
      seq_err_q     <= seq_err_d;
      frm_err_q     <= frm_err_d;
      locked_q      <= locked_d;
      bit_offset_q  <= bit_offset_d;
    end
  end

  assign token_valid    = token_valid_q;
  assign token_index    = token_index_q;
  assign sync           = sync_q;
  assign sequence_error = seq_err_q;
  assign framing_error  = frm_err_q;
  assign locked         = locked_q;
  assign bit_offset     = bit_offset_q;

`ifdef TRIGGER_RX_ERROR_COUNTER_EN
  logic [15:0] error_count_q, error_count_d;
  logic [16:0] w_err_sum;

  // Both pulses in one cycle add two; the sum saturates instead of wrapping.
  always_comb begin
    w_err_sum     = {1'b0, error_count_q} + {16'd0, seq_err_d} + {16'd0, frm_err_d};
    error_count_d = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_count_q <= 16'd0;
    end else begin
      error_count_q <= error_count_d;
    end
  end

  assign error_count = error_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trigger_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_word_receiver
// Description : Self-checking bench for trigger_word_receiver. A behavioural
//               model keeps the recent bit history as an integer and applies
//               the acquisition / tracking rules directly; directed scenarios
//               plus a randomized token stream are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_word_receiver;

  localparam int LOSS = 4;

  logic        clock;
  logic        reset_n;
  logic [7:0]  data_in;
  logic        token_valid;
  logic [1:0]  token_index;
  logic        sync;
  logic        sequence_error;
  logic        framing_error;
  logic        locked;
  logic [2:0]  bit_offset;
  logic [15:0] cnt_obs;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int mwin, m_locked, m_off, m_exp, m_bad;
  int e_tv, e_idx, e_sync, e_seq, e_frm, e_cnt;

`ifdef TRIGGER_RX_ERROR_COUNTER_EN
  logic [15:0] error_count;
  assign cnt_obs = error_count;
`else
  assign cnt_obs = 16'd0;
`endif

  trigger_word_receiver #(.WIDTH(8), .LOSS_THRESHOLD(LOSS)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .token_valid    (token_valid),
    .token_index    (token_index),
    .sync           (sync),
    .sequence_error (sequence_error),
    .framing_error  (framing_error),
    .locked         (locked),
    .bit_offset     (bit_offset)
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
    ,
    .error_count    (error_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic int tok_of(input int c);
    if (c == 'hF0) return 0;
    if (c == 'h81) return 1;
    if (c == 'h88) return 2;
    if (c == 'hAA) return 3;
    return -1;
  endfunction

  function automatic logic [25:0] obs_vec();
    return {token_valid, token_index, sync, sequence_error, framing_error,
            locked, bit_offset, cnt_obs};
  endfunction

  function automatic logic [25:0] exp_vec();
    logic [15:0] c;
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
    c = 16'(e_cnt);
`else
    c = 16'd0;
`endif
    return {1'(e_tv), 2'(e_idx), 1'(e_sync), 1'(e_seq), 1'(e_frm),
            1'(m_locked), 3'(m_off), c};
  endfunction

  task automatic model_reset();
    mwin = 0; m_locked = 0; m_off = 0; m_exp = 0; m_bad = 0;
    e_tv = 0; e_idx = 0; e_sync = 0; e_seq = 0; e_frm = 0; e_cnt = 0;
  endtask

  // Outputs after the next edge come from the window held now; the new word
  // then shifts into the history.
  task automatic model_step(input logic [7:0] d);
    int idx, found, c;
    e_tv = 0; e_sync = 0; e_seq = 0; e_frm = 0;
    if (m_locked == 0) begin
      found = -1;
      for (int s = 0; s < 8; s++) begin
        c = (mwin >> s) & 'hFF;
        if (found < 0 && (mwin >> (s + 8)) == 0 && tok_of(c) >= 0) found = s;
      end
      if (found >= 0) begin
        idx = tok_of((mwin >> found) & 'hFF);
        e_tv = 1; e_idx = idx; e_sync = (idx == 0);
        m_locked = 1; m_off = found; m_exp = (idx + 1) % 4;
      end
    end else begin
      c = (mwin >> m_off) & 'hFF;
      idx = tok_of(c);
      if (c == 0) begin
      end else if (idx >= 0) begin
        e_tv = 1; e_idx = idx; e_sync = (idx == 0);
        e_seq = (idx != m_exp);
        m_exp = (idx + 1) % 4;
        m_bad = 0;
      end else begin
        e_frm = 1;
        m_bad = (m_bad < 15) ? m_bad + 1 : 15;
        if (m_bad == LOSS) begin
          m_locked = 0; m_off = 0; m_bad = 0; m_exp = 0;
        end
      end
    end
    e_cnt = e_cnt + e_seq + e_frm;
    if (e_cnt > 'hFFFF) e_cnt = 'hFFFF;
    mwin = ((mwin << 8) | int'(d)) & 'hFFFF;
  endtask

  // Called at a falling edge; returns at the following falling edge.
  task automatic drive(input logic [7:0] d);
    data_in = d;
    model_step(d);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_vec() !== 26'd0) $display("FAIL reset_state: got %h expected 0", obs_vec());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(8'h00);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_acquire(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] off);
    logic [7:0] seq [4];
    seq = '{8'h00, a, b, 8'h00};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL %s_model: got %h expected %h", name, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({token_valid, token_index, sync, locked, bit_offset} !== {1'b1, 2'd0, 1'b1, 1'b1, off})
      $display("FAIL %s: got tv=%0b idx=%0d sync=%0b lk=%0b off=%0d expected off=%0d",
               name, token_valid, token_index, sync, locked, bit_offset, off);
    else n_pass++;
  endtask

  task automatic test_full_cycle();
    logic [7:0] seq [11];
    int got[$];
    int n_sync;
    seq = '{8'hF0, 8'h00, 8'h81, 8'h00, 8'h88, 8'h00, 8'hAA, 8'h00, 8'hF0, 8'h00, 8'h00};
    n_sync = 0;
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL full_cycle_model: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
      if (token_valid) got.push_back(int'(token_index));
      if (sync) n_sync++;
      if (sequence_error || framing_error) n_sync += 100;
    end
    n_checks++;
    if (got.size() != 5 || got[0] != 0 || got[1] != 1 || got[2] != 2 || got[3] != 3 || got[4] != 0 || n_sync != 2)
      $display("FAIL full_cycle: got %0d tokens, sync/err score %0d expected 5 tokens 0,1,2,3,0 score 2",
               got.size(), n_sync);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [8];
    int n_tv, n_err;
    seq = '{8'h00, 8'hF0, 8'h81, 8'h88, 8'hAA, 8'hF0, 8'h00, 8'h00};
    n_tv = 0; n_err = 0;
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL back_to_back_model: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
      n_tv += int'(token_valid);
      n_err += int'(sequence_error) + int'(framing_error);
    end
    n_checks++;
    if (n_tv != 5 || n_err != 0)
      $display("FAIL back_to_back: got %0d tokens %0d errors expected 5 tokens 0 errors", n_tv, n_err);
    else n_pass++;
  endtask

  // Leaves the receiver locked at offset 0 with one sequence error recorded.
  task automatic test_skip();
    logic [7:0] seq [8];
    int n_seq, seq_idx, late_err;
    seq = '{8'h00, 8'hF0, 8'h00, 8'h88, 8'h00, 8'hAA, 8'h00, 8'h00};
    n_seq = 0; seq_idx = -1; late_err = 0;
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL skip_model: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
      if (sequence_error) begin
        n_seq++;
        if (seq_idx < 0) seq_idx = int'(token_index);
        else late_err++;
      end
    end
    n_checks++;
    if (n_seq != 1 || seq_idx != 2 || late_err != 0)
      $display("FAIL skip: got %0d seq errors first idx %0d expected 1 error idx 2", n_seq, seq_idx);
    else n_pass++;
  endtask

  task automatic test_loss();
    logic [7:0] seq [9];
    int n_frm;
    seq = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00};
    n_frm = 0;
    foreach (seq[i]) begin
      drive(seq[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL loss_model: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
      n_frm += int'(framing_error);
      if (i == 6) begin
        n_checks++;
        if (n_frm != 4 || locked !== 1'b0 || bit_offset !== 3'd0)
          $display("FAIL loss_drop: got %0d framing pulses locked=%0b expected 4 and 0", n_frm, locked);
        else n_pass++;
      end
    end
    n_checks++;
    if ({token_valid, token_index, locked} !== {1'b1, 2'd1, 1'b1})
      $display("FAIL loss_reacquire: got tv=%0b idx=%0d lk=%0b expected 1 1 1", token_valid, token_index, locked);
    else n_pass++;
`ifdef TRIGGER_RX_ERROR_COUNTER_EN
    n_checks++;
    if (error_count !== 16'd5) $display("FAIL error_count: got %0d expected 5", error_count);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int n_tv;
    n_tv = 0;
    do_reset();
    drive(8'h00); drive(8'hF0); drive(8'h00); drive(8'h00);
    data_in = 8'h81;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== 26'd0) $display("FAIL reset_mid_async: got %h expected 0", obs_vec());
    else n_pass++;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (obs_vec() !== 26'd0) $display("FAIL reset_mid_held: got %h expected 0", obs_vec());
    else n_pass++;
    @(negedge clock);
    data_in = 8'h00;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(8'h00);
      n_tv += int'(token_valid) + int'(locked);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_mid_after: got %h expected %h", obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (n_tv != 0) $display("FAIL reset_mid_discard: got %0d pulses expected 0", n_tv);
    else n_pass++;
  endtask

  task automatic test_random();
    bit bq[$];
    int nxt, mism, gap, g;
    logic [7:0] w;
    logic [7:0] tokens [4];
    tokens = '{8'hF0, 8'h81, 8'h88, 8'hAA};
    nxt = 0; mism = 0;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      for (int b = 0; b < gap; b++) bq.push_back(1'b0);
      if ($urandom_range(0, 9) == 0) begin
        g = int'($urandom_range(1, 255));
        while (tok_of(g) >= 0) g = int'($urandom_range(1, 255));
        w = 8'(g);
      end else begin
        if ($urandom_range(0, 9) == 0) nxt = int'($urandom_range(0, 3));
        w = tokens[nxt];
        nxt = (nxt + 1) % 4;
      end
      for (int b = 7; b >= 0; b--) bq.push_back(w[b]);
    end
    while (bq.size() % 8 != 0) bq.push_back(1'b0);
    while (bq.size() > 0) begin
      for (int b = 7; b >= 0; b--) w[b] = bq.pop_front();
      drive(w);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        if (mism < 10) $display("FAIL random_stream: got %h expected %h", obs_vec(), exp_vec());
        mism++;
      end else n_pass++;
    end
  endtask

  initial begin
    clock   = 1'b0;
    reset_n = 1'b0;
    data_in = 8'h00;
    model_reset();
    test_reset();
    test_acquire("aligned_acq", 8'h00, 8'hF0, 3'd0);
    test_acquire("shifted_acq", 8'h07, 8'h80, 3'd3);
    test_full_cycle();
    test_back_to_back();
    test_skip();
    test_loss();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
